// File: rtl/transform_pkg.sv
// Shared types and helpers for the separable-transform loop sequencer:
// FSM state encoding, default geometry and address packing.
package transform_pkg;

  localparam int DEF_LOG2N   = 3;
  localparam int DEF_MEM_LAT = 1;

  // Widest per-coordinate field the packing helper can handle.
  localparam int MAX_LOG2N = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } state_t;

  // Concatenate two coordinates {hi,lo} where each field is log2n bits wide.
  // Callers size-cast the result down to 2*log2n bits.
  function automatic logic [2*MAX_LOG2N-1:0] pack_addr(
    input logic [MAX_LOG2N-1:0] hi,
    input logic [MAX_LOG2N-1:0] lo,
    input int unsigned          log2n
  );
    logic [2*MAX_LOG2N-1:0] hi_w;
    hi_w = {{MAX_LOG2N{1'b0}}, hi};
    return (hi_w << log2n) | {{MAX_LOG2N{1'b0}}, lo};
  endfunction

endpackage

// File: rtl/transform_loop_ctrl_latency_pipe.sv
// Fixed-depth shift register that delays a small bundle of control bits.
// Shifts every cycle and never stalls; synchronous active-low clear.
module latency_pipe #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  // Next stage contents: new input at the head, everything else moves one step.
  // NOTE: every element is written on every path, so no latch can be inferred.
  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Stage registers; clear wipes in-flight enables so nothing leaks past reset.
  // NOTE: non-blocking assignments so all stages update together on the edge;
  // this array is control state, so unlike a data RAM it must be reset.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/transform_loop_ctrl.sv
// Loop sequencer for an N x N separable transform: walks outputs (x,y),
// streams every input (u,v) to memory, lines up MAC enables with read
// latency and hands each finished accumulation out via valid/ready.
module transform_loop_ctrl
  import transform_pkg::*;
#(
  parameter int LOG2N   = DEF_LOG2N,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               inverse,
  input  logic               result_ready,
  output logic               busy,
  output logic               done,
  output logic               read_enable,
  output logic [2*LOG2N-1:0] sample_addr,
  output logic [2*LOG2N-1:0] coef_addr_row,
  output logic [2*LOG2N-1:0] coef_addr_col,
  output logic               mac_enable,
  output logic               mac_first,
  output logic               result_valid,
  output logic [2*LOG2N-1:0] result_addr
);

  localparam int          ADDR_W     = 2 * LOG2N;
  localparam int unsigned SHIFT      = LOG2N;
  localparam int          DRAIN_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MEM_LAT - 1);

  state_t             state_q, state_d;
  logic [LOG2N-1:0]   x_q, x_d, y_q, y_d, u_q, u_d, v_q, v_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               inv_q, inv_d;
  logic               first_issue;
  logic [1:0]         mac_bits;

  // Next-state, counter stepping and per-state control outputs.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    u_d          = u_q;
    v_d          = v_q;
    drain_d      = drain_q;
    inv_d        = inv_q;
    read_enable  = 1'b0;
    first_issue  = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;
    busy         = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        x_d = '0;
        y_d = '0;
        u_d = '0;
        v_d = '0;
        if (start) begin
          inv_d   = inverse;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        read_enable = 1'b1;
        first_issue = (u_q == '0) && (v_q == '0);
        // Modulo-N stepping: v wraps naturally, carrying into u.
        v_d = v_q + 1'b1;
        if (&v_q) begin
          u_d = u_q + 1'b1;
        end
        if ((&u_q) && (&v_q)) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_EMIT;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_EMIT: begin
        result_valid = 1'b1;
        if (result_ready) begin
          if ((&x_q) && (&y_q)) begin
            state_d = ST_DONE;
          end else begin
            y_d = y_q + 1'b1;
            if (&y_q) begin
              x_d = x_q + 1'b1;
            end
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        x_d     = '0;
        y_d     = '0;
        u_d     = '0;
        v_d     = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      drain_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      u_q     <= u_d;
      v_q     <= v_d;
      drain_q <= drain_d;
      inv_q   <= inv_d;
    end
  end

  // Address composition; inverse mode swaps the coefficient index order.
  assign sample_addr   = ADDR_W'(pack_addr(MAX_LOG2N'(u_q), MAX_LOG2N'(v_q), SHIFT));
  assign result_addr   = ADDR_W'(pack_addr(MAX_LOG2N'(x_q), MAX_LOG2N'(y_q), SHIFT));
  assign coef_addr_row = inv_q
    ? ADDR_W'(pack_addr(MAX_LOG2N'(u_q), MAX_LOG2N'(x_q), SHIFT))
    : ADDR_W'(pack_addr(MAX_LOG2N'(x_q), MAX_LOG2N'(u_q), SHIFT));
  assign coef_addr_col = inv_q
    ? ADDR_W'(pack_addr(MAX_LOG2N'(v_q), MAX_LOG2N'(y_q), SHIFT))
    : ADDR_W'(pack_addr(MAX_LOG2N'(y_q), MAX_LOG2N'(v_q), SHIFT));

  // Read enable and first-term flag travel MEM_LAT cycles to meet the data.
  latency_pipe #(
    .WIDTH(2),
    .DEPTH(MEM_LAT)
  ) u_mac_delay (
    .clock  (clock),
    .clear_n(reset),
    .din    ({read_enable, first_issue}),
    .dout   (mac_bits)
  );

  assign mac_enable = mac_bits[1];
  assign mac_first  = mac_bits[0];

endmodule

// File: doc/transform_loop_ctrl.md
# transform_loop_ctrl

Parametrised sequencer for the 2D separable transform datapath (DCT/IDCT over an N×N block, N = 2^LOG2N). It walks output indices (x,y) and, for each, streams all input indices (u,v) to sample memory at one read per cycle. It drives the MAC with a latency-matched enable and first-term flag, and presents each finished accumulation through a valid/ready handshake. It sits between the block-level start/done control and the sample RAM, coefficient ROM and MAC.

## Interface
Parameters:
- LOG2N, 3, log2 of block side; counters are LOG2N bits, N² terms per output.
- MEM_LAT, 1, sample/coefficient read latency in cycles (≥1); MAC enable lags read enable by this amount.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clock.
- start  in  1  begin a block; honoured only in IDLE.
- inverse  in  1  mode select, latched on accepted start; 0 = forward, 1 = inverse.
- result_ready  in  1  consumer accepts result this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after last result handshake.
- read_enable  out  1  sample/coef read request this cycle.
- sample_addr  out  2·LOG2N  {u,v}.
- coef_addr_row  out  2·LOG2N  forward {x,u}; inverse {u,x}.
- coef_addr_col  out  2·LOG2N  forward {y,v}; inverse {v,y}.
- mac_enable  out  1  read_enable delayed MEM_LAT cycles.
- mac_first  out  1  with mac_enable: load product instead of accumulate (first term of an output).
- result_valid  out  1  accumulator holds finished output.
- result_addr  out  2·LOG2N  {x,y} of presented result.

## Operation
- States: IDLE, ISSUE, DRAIN, EMIT, DONE.
- IDLE: counters x,y,u,v held at 0. start=1 → latch inverse, go ISSUE.
- ISSUE: read_enable=1 every cycle; addresses from current u,v,x,y; v increments, wraps N−1→0 with u increment. First issue of each (x,y) (u=v=0) carries a first-flag into the delay line. At u=v=N−1 go DRAIN, counter u,v wrap to 0.
- DRAIN: MEM_LAT cycles, read_enable=0; delay line flushes last terms into MAC.
- EMIT: result_valid=1, result_addr={x,y}. Stays while result_ready=0 (addr stable). On result_ready=1: if x=y=N−1 go DONE, else advance y (wrap with x increment) and go ISSUE.
- DONE: done=1 one cycle, counters cleared, go IDLE.
- Delay line (MEM_LAT deep, 2 bits: enable, first) shifts every cycle, never stalls.
- start outside IDLE ignored; inverse only sampled at accepted start.
- Counter arithmetic modulo N; no counter exceeds LOG2N bits.
- Reset: all outputs 0, counters 0, delay line cleared, state IDLE; mid-block reset abandons block without done pulse.

## Timing
- start sampled high at edge k (IDLE) → first read_enable in cycle k+1, sample_addr=0.
- Per output: N² ISSUE cycles, MEM_LAT DRAIN, ≥1 EMIT. Block without stall: N²·(N²+MEM_LAT+1)+1 cycles from first ISSUE to done.
- mac_enable/mac_first in cycle t+MEM_LAT for read in cycle t.
- result_valid asserts cycle after last mac_enable of that output.
- done asserts cycle after final handshake; busy falls with return to IDLE next cycle.

## Structure
- Package transform_pkg: state enumeration, default LOG2N/MEM_LAT constants, address-packing helper functions.
- Sub-module latency_pipe (parametrised width/depth shift register, synchronous active-low clear) for the mac_enable/mac_first delay.

## Test plan
- LOG2N=3, MEM_LAT=1, result_ready=1, start pulse → 64 consecutive reads sample_addr 0..63, result_valid in cycle 66 with result_addr 0; 64 results total, done once.
- Hold result_ready=0 for 5 cycles at result (0,3) → result_valid and result_addr=3 held 6 cycles, no read_enable, next block resumes at {x,y}=4.
- LOG2N=2, MEM_LAT=3 → mac_enable exactly 3 cycles after each read_enable, mac_first only on u=v=0 terms, 16 results.
- inverse=1 at start, changed to 0 mid-block → coef_addr_row={u,x} for whole block.
- start pulsed while busy → ignored, no restart, one done.
- reset low during ISSUE of output 10 → next edge all outputs 0, IDLE, no done; new start runs full block from (0,0).
